// File: rtl/ad1_pkg.sv
// Shared constants and FSM encoding for the PmodAD1 responder.
package ad1_pkg;

  localparam int AD1_SAMPLE_W   = 12;
  localparam int AD1_LEAD_ZEROS = 4;
  localparam int AD1_FRAME_LEN  = AD1_LEAD_ZEROS + AD1_SAMPLE_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_HOLD  = 2'd2
  } ad1_state_e;

endpackage

// File: rtl/ad1_sync_edge.sv
// Multi-stage synchronizer with rise/fall detection on the synchronized copy.
// Every flop resets to the line's idle-high level so reset never fakes an edge.
module ad1_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_i,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= {STAGES{1'b1}};
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], async_i};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign rise_o = sync_q[STAGES-1] & ~prev_q;
  assign fall_o = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/ad1_responder.sv
// PmodAD1 slave model: replays two 12-bit samples as 16-bit serial frames,
// shifting on synchronized SCLK falling edges while CS is low.
module ad1_responder
  import ad1_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int LEAD_ZEROS  = AD1_LEAD_ZEROS
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    sclk_i,
  input  logic                    cs_i,
  input  logic [AD1_SAMPLE_W-1:0] sample1_i,
  input  logic [AD1_SAMPLE_W-1:0] sample2_i,
  output logic                    sdata1_o,
  output logic                    sdata2_o,
  output logic                    busy_o,
  output logic                    frame_done_o,
  output logic                    abort_o
);

  localparam int FRAME_W = LEAD_ZEROS + AD1_SAMPLE_W;
  localparam int CNT_W   = $clog2(FRAME_W);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_W - 1);

  logic sclk_fall_s, sclk_rise_unused;
  logic cs_fall_s, cs_rise_s;

  ad1_state_e         state_q, state_d;
  logic [FRAME_W-1:0] sr1_q, sr1_d, sr2_q, sr2_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               sdata1_d, sdata2_d, busy_d, frame_done_d, abort_d;

  ad1_sync_edge #(.STAGES(SYNC_STAGES)) u_sclk_sync (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .async_i (sclk_i),
    .rise_o  (sclk_rise_unused),
    .fall_o  (sclk_fall_s)
  );

  ad1_sync_edge #(.STAGES(SYNC_STAGES)) u_cs_sync (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .async_i (cs_i),
    .rise_o  (cs_rise_s),
    .fall_o  (cs_fall_s)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // CS rising always wins over a coincident SCLK fall, so an abort never shifts.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (cs_fall_s) state_d = ST_SHIFT;
        else           state_d = ST_IDLE;
      end
      ST_SHIFT: begin
        if (cs_rise_s)                             state_d = ST_IDLE;
        else if (sclk_fall_s && cnt_q == LAST_CNT) state_d = ST_HOLD;
        else                                       state_d = ST_SHIFT;
      end
      ST_HOLD: begin
        if (cs_rise_s) state_d = ST_IDLE;
        else           state_d = ST_HOLD;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    sr1_d = sr1_q;
    sr2_d = sr2_q;
    cnt_d = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (cs_fall_s) begin
          sr1_d = {{LEAD_ZEROS{1'b0}}, sample1_i};
          sr2_d = {{LEAD_ZEROS{1'b0}}, sample2_i};
          cnt_d = {CNT_W{1'b0}};
        end else begin
          cnt_d = cnt_q;
        end
      end
      ST_SHIFT: begin
        if (!cs_rise_s && sclk_fall_s) begin
          sr1_d = {sr1_q[FRAME_W-2:0], 1'b0};
          sr2_d = {sr2_q[FRAME_W-2:0], 1'b0};
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          cnt_d = cnt_q;
        end
      end
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sr1_q <= {FRAME_W{1'b0}};
      sr2_q <= {FRAME_W{1'b0}};
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      sr1_q <= sr1_d;
      sr2_q <= sr2_d;
      cnt_q <= cnt_d;
    end
  end

  // Outputs are decoded from next-state values so the flops add no latency.
  always_comb begin
    busy_d       = (state_d == ST_SHIFT);
    sdata1_d     = (state_d == ST_SHIFT) ? sr1_d[FRAME_W-1] : 1'b0;
    sdata2_d     = (state_d == ST_SHIFT) ? sr2_d[FRAME_W-1] : 1'b0;
    frame_done_d = (state_q == ST_SHIFT) && (state_d == ST_HOLD);
    abort_d      = (state_q == ST_SHIFT) && (state_d == ST_IDLE);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sdata1_o     <= 1'b0;
      sdata2_o     <= 1'b0;
      busy_o       <= 1'b0;
      frame_done_o <= 1'b0;
      abort_o      <= 1'b0;
    end else begin
      sdata1_o     <= sdata1_d;
      sdata2_o     <= sdata2_d;
      busy_o       <= busy_d;
      frame_done_o <= frame_done_d;
      abort_o      <= abort_d;
    end
  end

endmodule
